csr_fu: RTL and testbench
=========================

Name: csr_fu

Overview:
- Out-of-order backend functional unit that issues CSR instructions, ECALL and MRET to the machine-mode CSR register file. It is the requester side of that CSR access interface.
- Accepts one op from its reservation station and holds it until the op is the ROB head (non-speculative).
- Performs a single-cycle access and, for ECALL/MRET, emits a front-end redirect to mtvec/mepc.
- Returns the old CSR value to writeback through a valid/ready handshake.

Parameters:
ROB_IDX_W, 4, width of ROB entry index

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset (asserted at 0)
issue_valid  in  1  reservation station offers an op
issue_ready  out  1  unit can accept an op
issue_op  in  3  001 CSRRW, 010 CSRRS, 011 CSRRC, 100 ECALL, 101 MRET; other encodings are illegal
issue_addr  in  12  CSR address
issue_wdata  in  32  rs1 value or zero-extended zimm
issue_src_zero  in  1  rs1 index or zimm is zero
issue_pc  in  32  instruction PC
issue_rob_id  in  ROB_IDX_W  ROB tag
rob_head_valid  in  1  ROB head entry is valid
rob_head_id  in  ROB_IDX_W  ROB head tag
flush  in  1  speculative squash
csr_op  out  fu_op_e  access type to regfile
csr_addr  out  12  access address
csr_wdata  out  32  write operand
csr_pc  out  32  trapping PC
csr_rdata  in  32  regfile combinational read data
ecall  out  1  ECALL strobe
mret  out  1  MRET strobe
mtvec_addr  in  32  current mtvec
mepc_addr  in  32  current mepc
redirect_valid  out  1  front-end redirect strobe
redirect_pc  out  32  redirect target
wb_valid  out  1  result valid
wb_ready  in  1  writeback accepts
wb_rob_id  out  ROB_IDX_W  result tag
wb_data  out  32  old CSR value (0 for ECALL/MRET)

Behaviour:
- Reset, asynchronous on falling reset:
  - State is IDLE.
  - issue_ready=1.
  - All strobes, wb_valid, redirect_valid and data outputs are 0.
  - csr_op is idle (no CSR access).
- Idle csr_op value: any fu_op_e value outside {CSR_READ, CSR_WRITE, CSR_SET, CSR_CLEAR}. It is driven in every state except ACCESS.
- States: IDLE, WAIT_HEAD, ACCESS, REDIRECT, WB.
- IDLE:
  - issue_ready=1.
  - On issue_valid && issue_ready, latch op, addr, wdata, src_zero, pc and rob_id, then go to WAIT_HEAD.
  - Illegal issue_op is never accepted.
- WAIT_HEAD:
  - issue_ready=0.
  - flush → IDLE, op discarded; flush wins over a same-cycle head match.
  - rob_head_valid && rob_head_id==latched id → ACCESS.
- ACCESS (exactly 1 cycle):
  - csr_addr = latched addr; csr_wdata = latched wdata; csr_pc = latched pc.
  - CSRRW → CSR_WRITE.
  - CSRRS → CSR_SET, or CSR_READ if src_zero.
  - CSRRC → CSR_CLEAR, or CSR_READ if src_zero.
  - csr_rdata is registered into wb_data at the clock edge ending ACCESS, i.e. the pre-write value.
  - ECALL: ecall=1 for this cycle only; csr_op stays idle.
  - MRET: mret=1 for this cycle only; csr_op stays idle.
  - Next state: CSR ops → WB; ECALL/MRET → REDIRECT.
- REDIRECT (1 cycle):
  - redirect_valid=1.
  - redirect_pc = mtvec_addr for ECALL, mepc_addr for MRET, sampled combinationally this cycle.
  - wb_data is 0.
  - Next state: WB.
- WB:
  - wb_valid=1; wb_rob_id and wb_data are held stable until wb_ready.
  - On wb_valid && wb_ready → IDLE.
  - issue_ready=0.
- flush is ignored in ACCESS, REDIRECT and WB; the op is at the ROB head and is non-speculative.
- Latency: head match at cycle N → access at N+1 → wb_valid at N+2 (CSR ops) or N+3 (ECALL/MRET).
- Throughput: at most one op in flight. The next issue is accepted no earlier than the cycle after the WB handshake.
- ecall, mret and redirect_valid are single-cycle pulses and are never asserted together.

Optional Feature:
- Macro: CSR_FU_PERF_EN.
- Defined:
  - Adds output csr_wait_cycle (1 bit), high in every WAIT_HEAD cycle, for connection to an HPM counter enable.
  - Adds output csr_op_retire (1 bit), pulsing with each WB handshake.
- Undefined: both ports and their logic are absent; all other behaviour is identical.

Test Plan:
1. CSRRW addr 0x305, wdata 0x8000_0100, rob_id 3; head=3 two cycles later; regfile mtvec=0 → one ACCESS cycle with csr_op=CSR_WRITE, addr 0x305; then wb_valid, wb_rob_id=3, wb_data=0x0000_0000.
2. CSRRS addr 0xB00 with src_zero=1, csr_rdata=0x0000_1234 during ACCESS → csr_op=CSR_READ (no write); wb_data=0x0000_1234.
3. ECALL pc 0x8000_0040, mtvec 0x8000_0100 → ecall high exactly 1 cycle with csr_pc=0x8000_0040; next cycle redirect_valid=1, redirect_pc=0x8000_0100; then wb_valid, wb_data=0.
4. MRET with mepc 0x8000_0044 → mret 1 cycle; next cycle redirect_pc=0x8000_0044; no ecall pulse.
5. flush in the same cycle as the head match in WAIT_HEAD → no ACCESS, no wb_valid, issue_ready=1 next cycle; a new op is accepted normally.
6. wb_ready held 0 for 5 cycles → wb_valid, wb_data, wb_rob_id stable and issue_ready=0; then reset driven to 0 mid-WB → all outputs 0 immediately, state IDLE after release.

Source files
------------

// File: rtl/csr_fu.sv
// CSR / ECALL / MRET functional unit: holds one op until it reaches the ROB head, then accesses the CSR file.
// Optional HPM hooks (csr_wait_cycle, csr_op_retire) are built when CSR_FU_PERF_EN is defined.
package csr_fu_pkg;
  typedef enum logic [2:0] {
    CSR_NONE  = 3'd0,
    CSR_READ  = 3'd1,
    CSR_WRITE = 3'd2,
    CSR_SET   = 3'd3,
    CSR_CLEAR = 3'd4
  } fu_op_e;
endpackage

module csr_fu
  import csr_fu_pkg::*;
#(
  parameter int ROB_IDX_W = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 issue_valid,
  output logic                 issue_ready,
  input  logic [2:0]           issue_op,
  input  logic [11:0]          issue_addr,
  input  logic [31:0]          issue_wdata,
  input  logic                 issue_src_zero,
  input  logic [31:0]          issue_pc,
  input  logic [ROB_IDX_W-1:0] issue_rob_id,
  input  logic                 rob_head_valid,
  input  logic [ROB_IDX_W-1:0] rob_head_id,
  input  logic                 flush,
  output fu_op_e               csr_op,
  output logic [11:0]          csr_addr,
  output logic [31:0]          csr_wdata,
  output logic [31:0]          csr_pc,
  input  logic [31:0]          csr_rdata,
  output logic                 ecall,
  output logic                 mret,
  input  logic [31:0]          mtvec_addr,
  input  logic [31:0]          mepc_addr,
  output logic                 redirect_valid,
  output logic [31:0]          redirect_pc,
`ifdef CSR_FU_PERF_EN
  output logic                 csr_wait_cycle,
  output logic                 csr_op_retire,
`endif
  output logic                 wb_valid,
  input  logic                 wb_ready,
  output logic [ROB_IDX_W-1:0] wb_rob_id,
  output logic [31:0]          wb_data
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_WAIT   = 3'd1;
  localparam logic [2:0] ST_ACCESS = 3'd2;
  localparam logic [2:0] ST_REDIR  = 3'd3;
  localparam logic [2:0] ST_WB     = 3'd4;

  localparam logic [2:0] OP_CSRRW = 3'b001;
  localparam logic [2:0] OP_CSRRS = 3'b010;
  localparam logic [2:0] OP_CSRRC = 3'b011;
  localparam logic [2:0] OP_ECALL = 3'b100;
  localparam logic [2:0] OP_MRET  = 3'b101;

  logic [2:0]           state_q, state_d;
  logic [2:0]           op_q;
  logic [11:0]          addr_q;
  logic [31:0]          wdata_q;
  logic                 src_zero_q;
  logic [31:0]          pc_q;
  logic [ROB_IDX_W-1:0] rob_id_q;
  logic [31:0]          wb_data_q, wb_data_d;

  logic issueLegal;
  logic accept;
  logic headMatch;
  logic isSys;
  logic inAccess;

  assign issueLegal = (issue_op >= OP_CSRRW) && (issue_op <= OP_MRET);
  assign accept     = issue_valid && issue_ready && issueLegal;
  assign headMatch  = rob_head_valid && (rob_head_id == rob_id_q);
  assign isSys      = (op_q == OP_ECALL) || (op_q == OP_MRET);
  assign inAccess   = (state_q == ST_ACCESS);

  // Flush only squashes while the op is still speculative (WAIT_HEAD).
  always_comb begin
    state_d   = state_q;
    wb_data_d = wb_data_q;
    case (state_q)
      ST_IDLE:   if (accept) state_d = ST_WAIT;
      ST_WAIT: begin
        if (flush)          state_d = ST_IDLE;
        else if (headMatch) state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        wb_data_d = isSys ? 32'h0 : csr_rdata;
        state_d   = isSys ? ST_REDIR : ST_WB;
      end
      ST_REDIR:  state_d = ST_WB;
      ST_WB:     if (wb_ready) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    csr_op = CSR_NONE;
    if (inAccess) begin
      case (op_q)
        OP_CSRRW: csr_op = CSR_WRITE;
        OP_CSRRS: csr_op = src_zero_q ? CSR_READ : CSR_SET;
        OP_CSRRC: csr_op = src_zero_q ? CSR_READ : CSR_CLEAR;
        default:  csr_op = CSR_NONE;
      endcase
    end
  end

  assign issue_ready    = (state_q == ST_IDLE);
  assign csr_addr       = inAccess ? addr_q  : 12'h0;
  assign csr_wdata      = inAccess ? wdata_q : 32'h0;
  assign csr_pc         = inAccess ? pc_q    : 32'h0;
  assign ecall          = inAccess && (op_q == OP_ECALL);
  assign mret           = inAccess && (op_q == OP_MRET);
  assign redirect_valid = (state_q == ST_REDIR);
  assign redirect_pc    = redirect_valid ? ((op_q == OP_ECALL) ? mtvec_addr : mepc_addr) : 32'h0;
  assign wb_valid       = (state_q == ST_WB);
  assign wb_rob_id      = wb_valid ? rob_id_q  : '0;
  assign wb_data        = wb_valid ? wb_data_q : 32'h0;

`ifdef CSR_FU_PERF_EN
  assign csr_wait_cycle = (state_q == ST_WAIT);
  assign csr_op_retire  = wb_valid && wb_ready;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      op_q       <= 3'b000;
      addr_q     <= 12'h0;
      wdata_q    <= 32'h0;
      src_zero_q <= 1'b0;
      pc_q       <= 32'h0;
      rob_id_q   <= '0;
      wb_data_q  <= 32'h0;
    end else begin
      state_q   <= state_d;
      wb_data_q <= wb_data_d;
      if (accept) begin
        op_q       <= issue_op;
        addr_q     <= issue_addr;
        wdata_q    <= issue_wdata;
        src_zero_q <= issue_src_zero;
        pc_q       <= issue_pc;
        rob_id_q   <= issue_rob_id;
      end
    end
  end

endmodule

// File: tb/tb_csr_fu.sv
// Self-checking bench for csr_fu: directed vector table, hand-written corner sequences,
// and randomized ops checked against a behavioural model of the CSR access rules.
module tb_csr_fu;
  import csr_fu_pkg::*;

  localparam int ROB_IDX_W = 4;

  logic                 clock = 1'b0;
  logic                 reset;
  logic                 issue_valid;
  logic                 issue_ready;
  logic [2:0]           issue_op;
  logic [11:0]          issue_addr;
  logic [31:0]          issue_wdata;
  logic                 issue_src_zero;
  logic [31:0]          issue_pc;
  logic [ROB_IDX_W-1:0] issue_rob_id;
  logic                 rob_head_valid;
  logic [ROB_IDX_W-1:0] rob_head_id;
  logic                 flush;
  fu_op_e               csr_op;
  logic [11:0]          csr_addr;
  logic [31:0]          csr_wdata;
  logic [31:0]          csr_pc;
  logic [31:0]          csr_rdata;
  logic                 ecall;
  logic                 mret;
  logic [31:0]          mtvec_addr;
  logic [31:0]          mepc_addr;
  logic                 redirect_valid;
  logic [31:0]          redirect_pc;
  logic                 wb_valid;
  logic                 wb_ready;
  logic [ROB_IDX_W-1:0] wb_rob_id;
  logic [31:0]          wb_data;
`ifdef CSR_FU_PERF_EN
  logic                 csrWaitCycle;
  logic                 csrOpRetire;
`endif

  int testsRun    = 0;
  int testsFailed = 0;

  csr_fu #(.ROB_IDX_W(ROB_IDX_W)) dut (
    .clock(clock), .reset(reset),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
    .issue_addr(issue_addr), .issue_wdata(issue_wdata), .issue_src_zero(issue_src_zero),
    .issue_pc(issue_pc), .issue_rob_id(issue_rob_id),
    .rob_head_valid(rob_head_valid), .rob_head_id(rob_head_id), .flush(flush),
    .csr_op(csr_op), .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_pc(csr_pc),
    .csr_rdata(csr_rdata), .ecall(ecall), .mret(mret),
    .mtvec_addr(mtvec_addr), .mepc_addr(mepc_addr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
`ifdef CSR_FU_PERF_EN
    .csr_wait_cycle(csrWaitCycle), .csr_op_retire(csrOpRetire),
`endif
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rob_id(wb_rob_id), .wb_data(wb_data)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [2:0]  op;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic        srcZero;
    logic [31:0] pc;
    logic [3:0]  robId;
    int          headDelay;
    logic [31:0] rdata;
    logic [31:0] mtvec;
    logic [31:0] mepc;
    int          wbDelay;
    fu_op_e      expOp;
    logic        expEcall;
    logic        expMret;
    logic [31:0] expRedirect;
    logic [31:0] expWbData;
  } vec_t;

  vec_t table_q[$];

  function automatic vec_t makeVec(
    input logic [2:0] op, input logic [11:0] addr, input logic [31:0] wdata, input logic srcZero,
    input logic [31:0] pc, input logic [3:0] robId, input int headDelay, input logic [31:0] rdata,
    input logic [31:0] mtvec, input logic [31:0] mepc, input int wbDelay,
    input fu_op_e expOp, input logic expEcall, input logic expMret,
    input logic [31:0] expRedirect, input logic [31:0] expWbData);
    vec_t v;
    v.op = op; v.addr = addr; v.wdata = wdata; v.srcZero = srcZero; v.pc = pc; v.robId = robId;
    v.headDelay = headDelay; v.rdata = rdata; v.mtvec = mtvec; v.mepc = mepc; v.wbDelay = wbDelay;
    v.expOp = expOp; v.expEcall = expEcall; v.expMret = expMret;
    v.expRedirect = expRedirect; v.expWbData = expWbData;
    return v;
  endfunction

  // Reference model: CSR access kind, redirect target and returned value from the ISA rules.
  function automatic fu_op_e modelCsrOp(input logic [2:0] op, input logic srcZero);
    case (op)
      3'd1:    return CSR_WRITE;
      3'd2:    return srcZero ? CSR_READ : CSR_SET;
      3'd3:    return srcZero ? CSR_READ : CSR_CLEAR;
      default: return CSR_NONE;
    endcase
  endfunction

  function automatic vec_t modelFill(input vec_t v);
    vec_t r = v;
    r.expOp       = modelCsrOp(v.op, v.srcZero);
    r.expEcall    = (v.op == 3'd4);
    r.expMret     = (v.op == 3'd5);
    r.expRedirect = (v.op == 3'd4) ? v.mtvec : (v.op == 3'd5) ? v.mepc : 32'h0;
    r.expWbData   = (v.op == 3'd4 || v.op == 3'd5) ? 32'h0 : v.rdata;
    return r;
  endfunction

  function automatic logic opIsIdle();
    return !(csr_op inside {CSR_READ, CSR_WRITE, CSR_SET, CSR_CLEAR});
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Runs one op through IDLE -> WAIT_HEAD -> ACCESS -> (REDIRECT) -> WB, checking every cycle.
  task automatic applyStimulus(input vec_t v);
    issue_valid = 1'b1; issue_op = v.op; issue_addr = v.addr; issue_wdata = v.wdata;
    issue_src_zero = v.srcZero; issue_pc = v.pc; issue_rob_id = v.robId;
    rob_head_valid = 1'b0; flush = 1'b0; wb_ready = 1'b0;
    #1;
    checkOutput("issue_ready idle", 32'(issue_ready), 32'd1);
    tick();
    issue_valid = 1'b0;
    for (int c = 0; c < v.headDelay; c++) begin
      rob_head_valid = c[0];
      rob_head_id = v.robId + 4'd1;
      #1;
      checkOutput("issue_ready wait", 32'(issue_ready), 32'd0);
      checkOutput("csr_op idle wait", 32'(opIsIdle()), 32'd1);
      checkOutput("wb_valid wait", 32'(wb_valid), 32'd0);
      tick();
    end
    rob_head_valid = 1'b1; rob_head_id = v.robId;
    #1;
    checkOutput("issue_ready match", 32'(issue_ready), 32'd0);
    tick();
    rob_head_valid = 1'b0; csr_rdata = v.rdata; mtvec_addr = v.mtvec; mepc_addr = v.mepc;
    flush = 1'($urandom_range(0, 1));
    #1;
    if (v.expOp == CSR_NONE) checkOutput("csr_op idle sys", 32'(opIsIdle()), 32'd1);
    else                     checkOutput("csr_op access", 32'(csr_op), 32'(v.expOp));
    checkOutput("csr_addr", 32'(csr_addr), 32'(v.addr));
    checkOutput("csr_wdata", csr_wdata, v.wdata);
    checkOutput("csr_pc", csr_pc, v.pc);
    checkOutput("ecall access", 32'(ecall), 32'(v.expEcall));
    checkOutput("mret access", 32'(mret), 32'(v.expMret));
    checkOutput("redirect_valid access", 32'(redirect_valid), 32'd0);
    checkOutput("wb_valid access", 32'(wb_valid), 32'd0);
    tick();
    csr_rdata = ~v.rdata;
    if (v.expEcall || v.expMret) begin
      #1;
      checkOutput("redirect_valid", 32'(redirect_valid), 32'd1);
      checkOutput("redirect_pc", redirect_pc, v.expRedirect);
      checkOutput("ecall after", 32'(ecall), 32'd0);
      checkOutput("mret after", 32'(mret), 32'd0);
      checkOutput("wb_data redirect", wb_data, 32'h0);
      checkOutput("wb_valid redirect", 32'(wb_valid), 32'd0);
      tick();
    end
    for (int c = 0; c <= v.wbDelay; c++) begin
      wb_ready = (c == v.wbDelay);
      flush = 1'($urandom_range(0, 1));
      #1;
      checkOutput("wb_valid", 32'(wb_valid), 32'd1);
      checkOutput("wb_rob_id", 32'(wb_rob_id), 32'(v.robId));
      checkOutput("wb_data", wb_data, v.expWbData);
      checkOutput("issue_ready wb", 32'(issue_ready), 32'd0);
      checkOutput("redirect_valid wb", 32'(redirect_valid), 32'd0);
      tick();
    end
    wb_ready = 1'b0; flush = 1'b0;
    #1;
    checkOutput("issue_ready after wb", 32'(issue_ready), 32'd1);
    checkOutput("wb_valid after wb", 32'(wb_valid), 32'd0);
    tick();
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, " issue_ready"}, 32'(issue_ready), 32'd1);
    checkOutput({tag, " wb_valid"}, 32'(wb_valid), 32'd0);
    checkOutput({tag, " redirect_valid"}, 32'(redirect_valid), 32'd0);
    checkOutput({tag, " ecall"}, 32'(ecall), 32'd0);
    checkOutput({tag, " mret"}, 32'(mret), 32'd0);
    checkOutput({tag, " csr_op idle"}, 32'(opIsIdle()), 32'd1);
    checkOutput({tag, " csr_addr"}, 32'(csr_addr), 32'd0);
    checkOutput({tag, " csr_wdata"}, csr_wdata, 32'd0);
    checkOutput({tag, " csr_pc"}, csr_pc, 32'd0);
    checkOutput({tag, " redirect_pc"}, redirect_pc, 32'd0);
    checkOutput({tag, " wb_rob_id"}, 32'(wb_rob_id), 32'd0);
    checkOutput({tag, " wb_data"}, wb_data, 32'd0);
  endtask

  task automatic issueOnly(input logic [2:0] op, input logic [3:0] robId);
    issue_valid = 1'b1; issue_op = op; issue_addr = 12'h340; issue_wdata = 32'h1;
    issue_src_zero = 1'b0; issue_pc = 32'h8000_0200; issue_rob_id = robId;
    #1;
    tick();
    issue_valid = 1'b0;
  endtask

  initial begin
    vec_t v;
    reset = 1'b1;
    issue_valid = 1'b0; issue_op = 3'd0; issue_addr = 12'h0; issue_wdata = 32'h0;
    issue_src_zero = 1'b0; issue_pc = 32'h0; issue_rob_id = 4'd0;
    rob_head_valid = 1'b0; rob_head_id = 4'd0; flush = 1'b0;
    csr_rdata = 32'h0; mtvec_addr = 32'h0; mepc_addr = 32'h0; wb_ready = 1'b0;
    #2 reset = 1'b0;
    #1;
    checkResetOutputs("reset");
    @(posedge clock);
    #1 reset = 1'b1;

    table_q.push_back(makeVec(3'd1, 12'h305, 32'h8000_0100, 1'b0, 32'h8000_0000, 4'd3, 1, 32'h0,
                              32'h0, 32'h0, 0, CSR_WRITE, 1'b0, 1'b0, 32'h0, 32'h0));
    table_q.push_back(makeVec(3'd2, 12'hB00, 32'h0, 1'b1, 32'h8000_0004, 4'd5, 0, 32'h0000_1234,
                              32'h0, 32'h0, 0, CSR_READ, 1'b0, 1'b0, 32'h0, 32'h0000_1234));
    table_q.push_back(makeVec(3'd4, 12'h000, 32'h0, 1'b1, 32'h8000_0040, 4'd7, 2, 32'hDEAD_BEEF,
                              32'h8000_0100, 32'h8000_0044, 1, CSR_NONE, 1'b1, 1'b0, 32'h8000_0100, 32'h0));
    table_q.push_back(makeVec(3'd5, 12'h000, 32'h0, 1'b1, 32'h8000_0050, 4'd8, 0, 32'h0000_0055,
                              32'h8000_0100, 32'h8000_0044, 0, CSR_NONE, 1'b0, 1'b1, 32'h8000_0044, 32'h0));
    table_q.push_back(makeVec(3'd2, 12'h300, 32'h8, 1'b0, 32'h8000_0060, 4'd15, 3, 32'h0000_1800,
                              32'h0, 32'h0, 5, CSR_SET, 1'b0, 1'b0, 32'h0, 32'h0000_1800));
    table_q.push_back(makeVec(3'd3, 12'h344, 32'h80, 1'b0, 32'h8000_0064, 4'd0, 1, 32'hA5A5_A5A5,
                              32'h0, 32'h0, 2, CSR_CLEAR, 1'b0, 1'b0, 32'h0, 32'hA5A5_A5A5));
    table_q.push_back(makeVec(3'd3, 12'h341, 32'h0, 1'b1, 32'h8000_0068, 4'd9, 0, 32'h0000_0011,
                              32'h0, 32'h0, 0, CSR_READ, 1'b0, 1'b0, 32'h0, 32'h0000_0011));
    table_q.push_back(makeVec(3'd1, 12'h340, 32'h0, 1'b1, 32'h8000_006C, 4'd12, 0, 32'hFFFF_FFFF,
                              32'h0, 32'h0, 1, CSR_WRITE, 1'b0, 1'b0, 32'h0, 32'hFFFF_FFFF));
    foreach (table_q[i]) applyStimulus(table_q[i]);

    // Flush coinciding with the head match must discard the op.
    issueOnly(3'd1, 4'd2);
    rob_head_valid = 1'b1; rob_head_id = 4'd2; flush = 1'b1;
    #1;
    checkOutput("flush issue_ready wait", 32'(issue_ready), 32'd0);
    tick();
    flush = 1'b0;
    #1;
    checkOutput("flush issue_ready", 32'(issue_ready), 32'd1);
    checkOutput("flush no access", 32'(opIsIdle()), 32'd1);
    tick();
    rob_head_valid = 1'b0;
    #1;
    checkOutput("flush no wb", 32'(wb_valid), 32'd0);
    tick();
    applyStimulus(table_q[1]);

    // Illegal encodings are never accepted, even with the head pointing at their tag.
    for (int k = 0; k < 3; k++) begin
      issueOnly((k == 0) ? 3'd0 : (k == 1) ? 3'd6 : 3'd7, 4'd4);
      rob_head_valid = 1'b1; rob_head_id = 4'd4;
      #1;
      checkOutput("illegal stays idle", 32'(issue_ready), 32'd1);
      tick();
      rob_head_valid = 1'b0;
      #1;
      checkOutput("illegal no access", 32'(opIsIdle()), 32'd1);
      checkOutput("illegal no wb", 32'(wb_valid), 32'd0);
      tick();
    end

    // Reset asserted while stalled in WB clears everything immediately.
    issueOnly(3'd1, 4'd9);
    rob_head_valid = 1'b1; rob_head_id = 4'd9;
    tick();
    rob_head_valid = 1'b0; csr_rdata = 32'h0000_0077;
    tick();
    for (int c = 0; c < 2; c++) begin
      #1;
      checkOutput("pre-reset wb_valid", 32'(wb_valid), 32'd1);
      checkOutput("pre-reset wb_data", wb_data, 32'h0000_0077);
      tick();
    end
    #2 reset = 1'b0;
    #1;
    checkResetOutputs("mid-wb reset");
    @(posedge clock);
    #1 reset = 1'b1;
    #1;
    checkOutput("post-reset issue_ready", 32'(issue_ready), 32'd1);
    checkOutput("post-reset wb_valid", 32'(wb_valid), 32'd0);
    tick();

    for (int n = 0; n < 24; n++) begin
      v.op = 3'($urandom_range(1, 5));
      v.addr = 12'($urandom);
      v.wdata = $urandom;
      v.srcZero = 1'($urandom_range(0, 1));
      v.pc = $urandom;
      v.robId = 4'($urandom);
      v.headDelay = $urandom_range(0, 3);
      v.rdata = $urandom;
      v.mtvec = $urandom;
      v.mepc = $urandom;
      v.wbDelay = $urandom_range(0, 3);
      applyStimulus(modelFill(v));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
